// File: rtl/najla_ln_frame_stats.sv
// Frames the Q30 ln/log10 sample stream and reports per-frame ln sum, rounded ln mean and log10 min/max.
// Optional macro NAJLA_FRAME_FLUSH_EN adds in_flush to close a partial frame early.
module najla_ln_frame_stats #(
  parameter int LOG2_FRAME = 4,
  parameter int SW         = 64 + LOG2_FRAME
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [63:0]         in_ln_q30,
  input  logic [63:0]         in_log10_q30,
`ifdef NAJLA_FRAME_FLUSH_EN
  input  logic                in_flush,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SW-1:0]       out_sum_ln_q30,
  output logic [63:0]         out_mean_ln_q30,
  output logic [63:0]         out_min_log10_q30,
  output logic [63:0]         out_max_log10_q30,
  output logic [LOG2_FRAME:0] out_count
);

  localparam int                    FRAME_LEN = 1 << LOG2_FRAME;
  localparam int                    CW        = LOG2_FRAME + 1;
  localparam logic [CW-1:0]         CNT_LAST  = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0]         CNT_FULL  = CW'(FRAME_LEN);
  localparam logic [CW-1:0]         CNT_ZERO  = CW'(0);
  localparam logic signed [SW-1:0]  HALF      = SW'(FRAME_LEN / 2);
  localparam logic signed [63:0]    POS_MAX   = {1'b0, {63{1'b1}}};
  localparam logic signed [63:0]    NEG_MAX   = {1'b1, {63{1'b0}}};

  logic [CW-1:0]        cnt_q, cnt_d, cnt_inc_s;
  logic signed [SW-1:0] acc_sum_q, acc_sum_d, sum_inc_s, rounded_s;
  logic signed [63:0]   acc_min_q, acc_min_d, min_inc_s;
  logic signed [63:0]   acc_max_q, acc_max_d, max_inc_s;
  logic signed [63:0]   sample_log10_s;
  logic                 out_valid_q, out_valid_d;
  logic [SW-1:0]        out_sum_q, out_sum_d;
  logic [63:0]          out_mean_q, out_mean_d, mean_s;
  logic [63:0]          out_min_q, out_min_d;
  logic [63:0]          out_max_q, out_max_d;
  logic [CW-1:0]        out_count_q, out_count_d;
  logic                 flush_req_s, in_ready_s, accept_s, close_s;

`ifdef NAJLA_FRAME_FLUSH_EN
  assign flush_req_s = in_flush;
`else
  assign flush_req_s = 1'b0;
`endif

  // A closing transfer (last sample or flush) may not overwrite a result still held downstream.
  assign in_ready_s = !out_valid_q || out_ready || ((cnt_q != CNT_LAST) && !flush_req_s);
  assign accept_s   = in_valid && in_ready_s;
  assign close_s    = (accept_s && (cnt_q == CNT_LAST)) ||
                      (flush_req_s && in_ready_s && (cnt_inc_s != CNT_ZERO));

  always_comb begin
    sample_log10_s = $signed(in_log10_q30);
    if (accept_s) begin
      sum_inc_s = acc_sum_q + {{LOG2_FRAME{in_ln_q30[63]}}, in_ln_q30};
      cnt_inc_s = cnt_q + CW'(1);
      if (sample_log10_s < acc_min_q) begin
        min_inc_s = sample_log10_s;
      end else begin
        min_inc_s = acc_min_q;
      end
      if (sample_log10_s > acc_max_q) begin
        max_inc_s = sample_log10_s;
      end else begin
        max_inc_s = acc_max_q;
      end
    end else begin
      sum_inc_s = acc_sum_q;
      cnt_inc_s = cnt_q;
      min_inc_s = acc_min_q;
      max_inc_s = acc_max_q;
    end
  end

  // Partial (flushed) frames report a zero mean; full frames round half toward +inf.
  always_comb begin
    rounded_s = sum_inc_s + HALF;
    if (cnt_inc_s == CNT_FULL) begin
      mean_s = 64'(rounded_s >>> LOG2_FRAME);
    end else begin
      mean_s = 64'd0;
    end
  end

  always_comb begin
    if (close_s) begin
      cnt_d       = CNT_ZERO;
      acc_sum_d   = {SW{1'b0}};
      acc_min_d   = POS_MAX;
      acc_max_d   = NEG_MAX;
      out_valid_d = 1'b1;
      out_sum_d   = sum_inc_s;
      out_mean_d  = mean_s;
      out_min_d   = min_inc_s;
      out_max_d   = max_inc_s;
      out_count_d = cnt_inc_s;
    end else begin
      cnt_d       = cnt_inc_s;
      acc_sum_d   = sum_inc_s;
      acc_min_d   = min_inc_s;
      acc_max_d   = max_inc_s;
      out_valid_d = out_valid_q && !out_ready;
      out_sum_d   = out_sum_q;
      out_mean_d  = out_mean_q;
      out_min_d   = out_min_q;
      out_max_d   = out_max_q;
      out_count_d = out_count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= CNT_ZERO;
      acc_sum_q   <= {SW{1'b0}};
      acc_min_q   <= POS_MAX;
      acc_max_q   <= NEG_MAX;
      out_valid_q <= 1'b0;
      out_sum_q   <= {SW{1'b0}};
      out_mean_q  <= 64'd0;
      out_min_q   <= 64'd0;
      out_max_q   <= 64'd0;
      out_count_q <= CNT_ZERO;
    end else begin
      cnt_q       <= cnt_d;
      acc_sum_q   <= acc_sum_d;
      acc_min_q   <= acc_min_d;
      acc_max_q   <= acc_max_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_mean_q  <= out_mean_d;
      out_min_q   <= out_min_d;
      out_max_q   <= out_max_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready          = in_ready_s;
  assign out_valid         = out_valid_q;
  assign out_sum_ln_q30    = out_sum_q;
  assign out_mean_ln_q30   = out_mean_q;
  assign out_min_log10_q30 = out_min_q;
  assign out_max_log10_q30 = out_max_q;
  assign out_count         = out_count_q;

endmodule

// File: tb/tb_najla_ln_frame_stats.sv
// Randomized self-checking bench for najla_ln_frame_stats (LOG2_FRAME=3) against a list-based frame model.
module tb_najla_ln_frame_stats;
  localparam int L   = 3;
  localparam int N   = 8;
  localparam int SWB = 64 + L;

  typedef struct packed {
    logic signed [SWB-1:0] sum;
    logic [63:0]           mean;
    logic signed [63:0]    mn;
    logic signed [63:0]    mx;
    logic [L:0]            cnt;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [63:0] in_ln = 64'd0, in_lg = 64'd0;
  logic in_ready, out_valid;
  logic [SWB-1:0] o_sum;
  logic [63:0] o_mean, o_min, o_max;
  logic [L:0] o_cnt;
`ifdef NAJLA_FRAME_FLUSH_EN
  logic in_flush_s = 1'b0;
`endif

  always #5 clk = ~clk;

  najla_ln_frame_stats #(.LOG2_FRAME(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ln_q30(in_ln), .in_log10_q30(in_lg),
`ifdef NAJLA_FRAME_FLUSH_EN
    .in_flush(in_flush_s),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum_ln_q30(o_sum), .out_mean_ln_q30(o_mean),
    .out_min_log10_q30(o_min), .out_max_log10_q30(o_max),
    .out_count(o_cnt)
  );

  logic signed [63:0] cur_ln[$], cur_lg[$];
  res_t exp_q[$];
  res_t obs, got, want;
  logic obs_valid, acc, xfer, rdy, erdy;
  int n_checks = 0, n_pass = 0;

  // Reference: statistics of the sample list as plain arithmetic.
  function automatic res_t model_frame();
    res_t r;
    logic signed [SWB-1:0] s, nn, q, eight;
    s = '0;
    eight = 8;
    r.mn = cur_lg[0];
    r.mx = cur_lg[0];
    foreach (cur_ln[i]) begin
      s = s + cur_ln[i];
      if (cur_lg[i] < r.mn) r.mn = cur_lg[i];
      if (cur_lg[i] > r.mx) r.mx = cur_lg[i];
    end
    r.sum = s;
    if (cur_ln.size() == N) begin
      nn = s + 4;
      q = nn / eight;
      if (nn < 0 && (nn % eight) != 0) q = q - 1;
      r.mean = q[63:0];
    end else begin
      r.mean = 64'd0;
    end
    r.cnt = (L+1)'(cur_ln.size());
    return r;
  endfunction

  function automatic void model_close();
    exp_q.push_back(model_frame());
    cur_ln.delete();
    cur_lg.delete();
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    cur_ln.delete();
    cur_lg.delete();
  endfunction

  task automatic step(input logic v, input logic [63:0] ln, input logic [63:0] lg,
                      input logic ordy, input logic fl);
    @(negedge clk);
    in_valid = v; in_ln = ln; in_lg = lg; out_ready = ordy;
`ifdef NAJLA_FRAME_FLUSH_EN
    in_flush_s = fl;
`endif
    #1;
    obs_valid = out_valid;
    obs = {o_sum, o_mean, o_min, o_max, o_cnt};
    erdy = (exp_q.size() == 0) || ordy || ((cur_ln.size() != N-1) && !fl);
    rdy = in_ready;
    acc = v && rdy;
    xfer = out_valid && ordy;
    got = obs;
    if (xfer) begin
      if (exp_q.size() > 0) want = exp_q.pop_front();
      else want = '1;
    end
    if (acc) begin
      cur_ln.push_back(ln);
      cur_lg.push_back(lg);
    end
    if ((acc && cur_ln.size() == N) || (fl && rdy && cur_ln.size() > 0)) model_close();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else n_pass++;
    n_checks++;
    if ({o_sum, o_mean, o_min, o_max, o_cnt} !== '0) $display("FAIL reset_data got=%h want=0", {o_sum, o_mean, o_min, o_max, o_cnt}); else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else n_pass++;
  endtask

  task automatic test_basic();
    logic signed [63:0] lg_tab [8] = '{64'sd5, -64'sd2, 64'sd0, 64'sd1, 64'sd2, 64'sd3, 64'sd4, -64'sd1};
    res_t fixed;
    for (int k = 0; k < N; k++) step(1'b1, 64'(k + 1) << 30, lg_tab[k] <<< 30, 1'b1, 1'b0);
    n_checks++;
    if (obs_valid !== 1'b0) $display("FAIL basic_early_valid got=%b want=0", obs_valid); else n_pass++;
    step(1'b0, 64'd0, 64'd0, 1'b1, 1'b0);
    n_checks++;
    if (xfer !== 1'b1) $display("FAIL basic_latency got=%b want=1", xfer); else n_pass++;
    fixed.sum = 67'h9_0000_0000;
    fixed.mean = 64'h1_2000_0000;
    fixed.mn = 64'hFFFF_FFFF_8000_0000;
    fixed.mx = 64'h1_4000_0000;
    fixed.cnt = 4'd8;
    n_checks++;
    if (got !== fixed) $display("FAIL basic_values got=%h want=%h", got, fixed); else n_pass++;
    n_checks++;
    if (got !== want) $display("FAIL basic_model got=%h want=%h", got, want); else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL basic_valid_drop got=%b want=0", out_valid); else n_pass++;
  endtask

  task automatic test_round();
    for (int k = 0; k < N; k++)
      step(1'b1, (k < 4) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0, {$urandom, $urandom}, 1'b1, 1'b0);
    step(1'b0, 64'd0, 64'd0, 1'b1, 1'b0);
    n_checks++;
    if (got.sum !== -67'sd4) $display("FAIL round_sum got=%h want=-4", got.sum); else n_pass++;
    n_checks++;
    if (got.mean !== 64'd0) $display("FAIL round_mean got=%h want=0", got.mean); else n_pass++;
    n_checks++;
    if (xfer !== 1'b1 || got !== want) $display("FAIL round_model got=%h want=%h", got, want); else n_pass++;
  endtask

  task automatic test_stall();
    int n_acc = 0;
    logic [63:0] l8, g8;
    res_t held;
    for (int k = 0; k < 15; k++) begin
      step(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
      if (acc) n_acc++;
    end
    n_checks++;
    if (n_acc !== 15) $display("FAIL stall_accepts got=%0d want=15", n_acc); else n_pass++;
    held = exp_q[0];
    l8 = {$urandom, $urandom};
    g8 = {$urandom, $urandom};
    for (int k = 0; k < 3; k++) begin
      step(1'b1, l8, g8, 1'b0, 1'b0);
      n_checks++;
      if (rdy !== 1'b0) $display("FAIL stall_ready got=%b want=0", rdy); else n_pass++;
      n_checks++;
      if (obs_valid !== 1'b1 || obs !== held) $display("FAIL stall_hold got=%h want=%h", obs, held); else n_pass++;
    end
    step(1'b1, l8, g8, 1'b1, 1'b0);
    n_checks++;
    if (acc !== 1'b1 || xfer !== 1'b1) $display("FAIL stall_release acc=%b xfer=%b want=1,1", acc, xfer); else n_pass++;
    n_checks++;
    if (got !== want) $display("FAIL stall_result1 got=%h want=%h", got, want); else n_pass++;
    step(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    n_checks++;
    if (obs_valid !== 1'b1 || obs !== exp_q[0]) $display("FAIL stall_no_bubble valid=%b got=%h want=%h", obs_valid, obs, exp_q[0]); else n_pass++;
    step(1'b0, 64'd0, 64'd0, 1'b1, 1'b0);
    n_checks++;
    if (xfer !== 1'b1 || got !== want) $display("FAIL stall_result2 got=%h want=%h", got, want); else n_pass++;
  endtask

  task automatic test_random();
    int acc_n = 0, nres = 0, cyc = 0, bad_rdy = 0, bad_res = 0, bad_hold = 0;
    logic prev_hold = 1'b0;
    res_t prev_obs = '0;
    logic ordy;
    while (acc_n < 1024 && cyc < 20000) begin
      ordy = (cyc % 3) != 2;
      step($urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom}, ordy, 1'b0);
      if (rdy !== erdy) bad_rdy++;
      if (prev_hold && (obs_valid !== 1'b1 || obs !== prev_obs)) bad_hold++;
      if (xfer) begin
        nres++;
        if (got !== want) begin
          bad_res++;
          if (bad_res < 4) $display("FAIL random_result got=%h want=%h", got, want);
        end
      end
      if (acc) acc_n++;
      prev_hold = obs_valid && !ordy;
      prev_obs = obs;
      cyc++;
    end
    while (exp_q.size() > 0 && cyc < 20100) begin
      step(1'b0, 64'd0, 64'd0, 1'b1, 1'b0);
      if (xfer) begin
        nres++;
        if (got !== want) bad_res++;
      end
      cyc++;
    end
    n_checks++;
    if (acc_n !== 1024) $display("FAIL random_timeout accepted=%0d want=1024", acc_n); else n_pass++;
    n_checks++;
    if (bad_rdy !== 0) $display("FAIL random_in_ready bad=%0d want=0", bad_rdy); else n_pass++;
    n_checks++;
    if (bad_hold !== 0) $display("FAIL random_stable bad=%0d want=0", bad_hold); else n_pass++;
    n_checks++;
    if (bad_res !== 0) $display("FAIL random_results bad=%0d want=0", bad_res); else n_pass++;
    n_checks++;
    if (nres !== 128) $display("FAIL random_count got=%0d want=128", nres); else n_pass++;
  endtask

  task automatic test_midreset();
    for (int k = 0; k < N + 5; k++) step(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || o_sum !== '0 || o_cnt !== '0) $display("FAIL midreset_clear valid=%b sum=%h cnt=%0d want=0", out_valid, o_sum, o_cnt); else n_pass++;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) step(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
    step(1'b0, 64'd0, 64'd0, 1'b1, 1'b0);
    n_checks++;
    if (xfer !== 1'b1 || got.cnt !== 4'd8) $display("FAIL midreset_count xfer=%b got=%0d want=8", xfer, got.cnt); else n_pass++;
    n_checks++;
    if (got !== want) $display("FAIL midreset_frame got=%h want=%h", got, want); else n_pass++;
  endtask

`ifdef NAJLA_FRAME_FLUSH_EN
  task automatic test_flush();
    step(1'b0, 64'd0, 64'd0, 1'b1, 1'b1);
    step(1'b0, 64'd0, 64'd0, 1'b1, 1'b0);
    n_checks++;
    if (obs_valid !== 1'b0) $display("FAIL flush_empty got=%b want=0", obs_valid); else n_pass++;
    for (int k = 0; k < 3; k++) step(1'b1, 64'd2 << 30, {$urandom, $urandom}, 1'b1, 1'b0);
    step(1'b0, 64'd0, 64'd0, 1'b1, 1'b1);
    step(1'b0, 64'd0, 64'd0, 1'b1, 1'b0);
    n_checks++;
    if (xfer !== 1'b1 || got.cnt !== 4'd3 || got.sum !== 67'sd6 <<< 30 || got.mean !== 64'd0)
      $display("FAIL flush_partial got=%h want cnt=3 sum=6<<30 mean=0", got); else n_pass++;
    n_checks++;
    if (got !== want) $display("FAIL flush_model got=%h want=%h", got, want); else n_pass++;
    for (int k = 0; k < N; k++) step(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
    step(1'b0, 64'd0, 64'd0, 1'b1, 1'b0);
    n_checks++;
    if (xfer !== 1'b1 || got !== want || got.cnt !== 4'd8) $display("FAIL flush_next got=%h want=%h", got, want); else n_pass++;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_round();
    test_stall();
    test_random();
    test_midreset();
`ifdef NAJLA_FRAME_FLUSH_EN
    test_flush();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
